// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer: opcode and FSM state enums,
// plus the divide-by-zero guard value used when ALU_SEQ_DIV_GUARD_EN is defined.
package alu_seq_pkg;

  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] DIV_GUARD_VAL = 8'hFF;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_MUL   = 4'h2,
    OP_DIV   = 4'h3,
    OP_MOD   = 4'h4,
    OP_AND   = 4'h5,
    OP_OR    = 4'h6,
    OP_XOR   = 4'h7,
    OP_NOT   = 4'h8,
    OP_SHL   = 4'h9,
    OP_SHR   = 4'hA,
    OP_ROL   = 4'hB,
    OP_ROR   = 4'hC,
    OP_PASSA = 4'hD,
    OP_INCA  = 4'hE,
    OP_INCB  = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } seq_state_e;

  // A divide whose divisor is zero gets the guard value instead of the ALU result.
  function automatic logic div_guard_hit(input alu_op_e op, input logic [DATA_W-1:0] b);
    return (op == OP_DIV) && (b == 8'h00);
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// NREGS x 8 register file: two combinational read ports, one synchronous write
// port, asynchronous active-low clear.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int NREGS = 4,
  parameter int RAW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RAW-1:0]    raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [RAW-1:0]    raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [RAW-1:0]    waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs_r [NREGS];

  // Storage with a single write port; reset clears every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= 8'h00;
      end
    end else if (we) begin
      regs_r[waddr] <= wdata;
    end
  end

  assign rdata1 = regs_r[raddr1];
  assign rdata2 = regs_r[raddr2];

endmodule

// File: rtl/alu_sequencer.sv
// Issues one instruction at a time to an external combinational ALU and returns
// results over valid/ready. Define ALU_SEQ_DIV_GUARD_EN to force 8'hFF + err on divide by zero.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NREGS = 4,
  parameter int RAW   = $clog2(NREGS)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic           instr_ld,
  input  logic [3:0]     instr_op,
  input  logic [RAW-1:0] instr_rd,
  input  logic [RAW-1:0] instr_rs1,
  input  logic [RAW-1:0] instr_rs2,
  input  logic [7:0]     instr_imm,
  output logic [7:0]     alu_a,
  output logic [7:0]     alu_b,
  output logic [3:0]     alu_opcode,
  input  logic [7:0]     alu_out,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [7:0]     res_data,
  output logic [RAW-1:0] res_rd,
  output logic           res_err
);

  seq_state_e     state_r, state_nx_s;
  logic [RAW-1:0] rd_r;
  logic [7:0]     alu_a_r, alu_b_r;
  alu_op_e        alu_opcode_r;
  logic [7:0]     res_data_r;
  logic [RAW-1:0] res_rd_r;
  logic           res_err_r;

  logic [7:0]     rdata1_s, rdata2_s;
  logic           we_s;
  logic [RAW-1:0] waddr_s;
  logic [7:0]     wdata_s;
  logic           issue_s, capture_s;
  logic [7:0]     result_s;
  logic           err_s;

  alu_seq_regfile #(.NREGS(NREGS), .RAW(RAW)) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (instr_rs1),
    .rdata1 (rdata1_s),
    .raddr2 (instr_rs2),
    .rdata2 (rdata2_s),
    .we     (we_s),
    .waddr  (waddr_s),
    .wdata  (wdata_s)
  );

`ifdef ALU_SEQ_DIV_GUARD_EN
  // Divide-by-zero substitutes the guard value and flags the result.
  always_comb begin
    if (div_guard_hit(alu_opcode_r, alu_b_r)) begin
      result_s = DIV_GUARD_VAL;
      err_s    = 1'b1;
    end else begin
      result_s = alu_out;
      err_s    = 1'b0;
    end
  end
`else
  // ALU result passes through untouched; no error reporting.
  always_comb begin
    result_s = alu_out;
    err_s    = 1'b0;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode; loads retire in IDLE, ALU results are written back in EXEC.
  always_comb begin
    state_nx_s = state_r;
    we_s       = 1'b0;
    waddr_s    = rd_r;
    wdata_s    = result_s;
    issue_s    = 1'b0;
    capture_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (instr_valid && instr_ld) begin
          we_s    = 1'b1;
          waddr_s = instr_rd;
          wdata_s = instr_imm;
        end else if (instr_valid) begin
          issue_s    = 1'b1;
          state_nx_s = ST_EXEC;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        we_s       = 1'b1;
        capture_s  = 1'b1;
        state_nx_s = ST_WB;
      end
      ST_WB: begin
        if (res_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_WB;
        end
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Operand latch on issue, result latch on capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_r      <= 8'h00;
      alu_b_r      <= 8'h00;
      alu_opcode_r <= OP_ADD;
      rd_r         <= '0;
      res_data_r   <= 8'h00;
      res_rd_r     <= '0;
      res_err_r    <= 1'b0;
    end else begin
      if (issue_s) begin
        alu_a_r      <= rdata1_s;
        alu_b_r      <= rdata2_s;
        alu_opcode_r <= alu_op_e'(instr_op);
        rd_r         <= instr_rd;
      end
      if (capture_s) begin
        res_data_r <= result_s;
        res_rd_r   <= rd_r;
        res_err_r  <= err_s;
      end
    end
  end

  assign instr_ready = (state_r == ST_IDLE);
  assign res_valid   = (state_r == ST_WB);
  assign alu_a       = alu_a_r;
  assign alu_b       = alu_b_r;
  assign alu_opcode  = alu_opcode_r;
  assign res_data    = res_data_r;
  assign res_rd      = res_rd_r;
  assign res_err     = res_err_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 8-bit ALU attached.
// The ALU model returns 8'hA5 for divide by zero so pass-through is visible.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid, instr_ready, instr_ld;
  logic [3:0] instr_op;
  logic [1:0] instr_rd, instr_rs1, instr_rs2;
  logic [7:0] instr_imm;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [3:0] alu_opcode;
  logic       res_valid, res_ready, res_err;
  logic [7:0] res_data;
  logic [1:0] res_rd;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.NREGS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_ld(instr_ld),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .instr_imm(instr_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_rd(res_rd), .res_err(res_err)
  );

  // Reference ALU.
  always_comb begin
    alu_out = 8'h00;
    case (alu_opcode)
      4'h0: alu_out = alu_a + alu_b;
      4'h1: alu_out = alu_a - alu_b;
      4'h2: alu_out = alu_a * alu_b;
      4'h3: alu_out = (alu_b == 8'h00) ? 8'hA5 : alu_a / alu_b;
      4'h4: alu_out = (alu_b == 8'h00) ? 8'hA5 : alu_a % alu_b;
      4'h5: alu_out = alu_a & alu_b;
      4'h6: alu_out = alu_a | alu_b;
      4'h7: alu_out = alu_a ^ alu_b;
      4'h8: alu_out = ~alu_a;
      4'h9: alu_out = {alu_a[6:0], 1'b0};
      4'hA: alu_out = {1'b0, alu_a[7:1]};
      4'hB: alu_out = {alu_a[6:0], alu_a[7]};
      4'hC: alu_out = {alu_a[0], alu_a[7:1]};
      4'hD: alu_out = alu_a;
      4'hE: alu_out = alu_a + 8'd1;
      4'hF: alu_out = alu_b + 8'd1;
      default: alu_out = 8'h00;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"},  32'(instr_ready), 32'h1);
    check_eq({tag, "_valid"},  32'(res_valid),   32'h0);
    check_eq({tag, "_err"},    32'(res_err),     32'h0);
    check_eq({tag, "_data"},   32'(res_data),    32'h0);
    check_eq({tag, "_rd"},     32'(res_rd),      32'h0);
    check_eq({tag, "_a"},      32'(alu_a),       32'h0);
    check_eq({tag, "_b"},      32'(alu_b),       32'h0);
    check_eq({tag, "_opcode"}, 32'(alu_opcode),  32'h0);
  endtask

  task automatic do_load(input logic [1:0] rd, input logic [7:0] imm);
    @(negedge clk);
    instr_valid = 1'b1; instr_ld = 1'b1; instr_rd = rd; instr_imm = imm;
    @(posedge clk); #1;
    instr_valid = 1'b0; instr_ld = 1'b0;
  endtask

  // Returns just after the accepting edge, i.e. while the DUT is in EXEC.
  task automatic issue_op(input logic [3:0] op, input logic [1:0] rd,
                          input logic [1:0] rs1, input logic [1:0] rs2);
    @(negedge clk);
    instr_valid = 1'b1; instr_ld = 1'b0; instr_op = op;
    instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int n = 0;
    while (!res_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_res_valid"}, 32'(res_valid), 32'h1);
  endtask

  task automatic take_result();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  // Full ALU op: issue, wait, check data/rd/err, consume.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [1:0] rd,
                        input logic [1:0] rs1, input logic [1:0] rs2,
                        input logic [7:0] exp_data, input logic exp_err);
    issue_op(op, rd, rs1, rs2);
    wait_result(tag);
    check_eq({tag, "_data"}, 32'(res_data), 32'(exp_data));
    check_eq({tag, "_rd"},   32'(res_rd),   32'(rd));
    check_eq({tag, "_err"},  32'(res_err),  32'(exp_err));
    take_result();
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr_ld = 1'b0; instr_op = 4'h0;
    instr_rd = 2'd0; instr_rs1 = 2'd0; instr_rs2 = 2'd0; instr_imm = 8'h00;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // ADD r2 = r0 + r1
    do_load(2'd0, 8'h0F);
    do_load(2'd1, 8'h01);
    issue_op(4'h0, 2'd2, 2'd0, 2'd1);
    check_eq("add_opcode", 32'(alu_opcode), 32'h0);
    check_eq("add_a", 32'(alu_a), 32'h0F);
    check_eq("add_b", 32'(alu_b), 32'h01);
    check_eq("add_exec_ready", 32'(instr_ready), 32'h0);
    wait_result("add");
    check_eq("add_data", 32'(res_data), 32'h10);
    check_eq("add_rd", 32'(res_rd), 32'h2);
    take_result();

    // SUB r3 = r1 - r0 wraps; stall 5 cycles in WB
    issue_op(4'h1, 2'd3, 2'd1, 2'd0);
    wait_result("sub");
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_valid", 32'(res_valid), 32'h1);
      check_eq("stall_data", 32'(res_data), 32'hF2);
      check_eq("stall_rd", 32'(res_rd), 32'h3);
      check_eq("stall_ready", 32'(instr_ready), 32'h0);
      @(negedge clk);
    end
    take_result();
    check_eq("release_valid", 32'(res_valid), 32'h0);
    check_eq("release_ready", 32'(instr_ready), 32'h1);

    // r2 was written with 0x10 (rs1 = rd)
    run_op("r2_read", 4'hD, 2'd2, 2'd2, 2'd2, 8'h10, 1'b0);

    // Divide by zero
    do_load(2'd1, 8'h00);
`ifdef ALU_SEQ_DIV_GUARD_EN
    run_op("div0", 4'h3, 2'd2, 2'd0, 2'd1, 8'hFF, 1'b1);
    run_op("div0_wb", 4'hD, 2'd3, 2'd2, 2'd2, 8'hFF, 1'b0);
`else
    run_op("div0", 4'h3, 2'd2, 2'd0, 2'd1, 8'hA5, 1'b0);
    run_op("div0_wb", 4'hD, 2'd3, 2'd2, 2'd2, 8'hA5, 1'b0);
`endif

    // SHL chain from 0x81
    do_load(2'd0, 8'h81);
    run_op("shl1", 4'h9, 2'd0, 2'd0, 2'd0, 8'h02, 1'b0);
    run_op("shl2", 4'h9, 2'd0, 2'd0, 2'd0, 8'h04, 1'b0);
    run_op("shl3", 4'h9, 2'd0, 2'd0, 2'd0, 8'h08, 1'b0);

    // Reset during EXEC discards result and write-back
    do_load(2'd1, 8'h33);
    issue_op(4'h0, 2'd2, 2'd0, 2'd1);
    check_eq("pre_rst_a", 32'(alu_a), 32'h08);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid_rst_hold");
    rst_n = 1'b1;
    run_op("clr_r2", 4'hD, 2'd2, 2'd2, 2'd2, 8'h00, 1'b0);
    run_op("clr_add", 4'h0, 2'd3, 2'd0, 2'd1, 8'h00, 1'b0);
    do_load(2'd0, 8'h02);
    do_load(2'd1, 8'h03);
    run_op("post_rst_add", 4'h0, 2'd3, 2'd0, 2'd1, 8'h05, 1'b0);
    run_op("mul", 4'h2, 2'd2, 2'd3, 2'd1, 8'h0F, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Issuing side of the 8-bit ALU interface. Accepts instructions over a valid/ready handshake and reads operands from a small internal register file. Drives `opcode`/`a`/`b` to the combinational ALU, captures its `out`, writes the result back and returns it over a second valid/ready handshake. Sits between the instruction source and the ALU, serialising one operation at a time.

## Interface
Parameters:
- `NREGS`, 4: number of 8-bit general registers (power of two, ≥2).
- `RAW`, $clog2(NREGS): register address width (derived; do not override).

Ports:
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `instr_valid` in 1: instruction present.
- `instr_ready` out 1: sequencer can accept.
- `instr_ld` in 1: 1 = load immediate, 0 = ALU op.
- `instr_op` in 4: ALU opcode (0000 add … 1111 b+1).
- `instr_rd`, `instr_rs1`, `instr_rs2` in RAW: destination and source registers.
- `instr_imm` in 8: immediate for loads.
- `alu_a`, `alu_b` out 8: ALU operands (registered).
- `alu_opcode` out 4: ALU opcode (registered).
- `alu_out` in 8: ALU result (combinational from `alu_a/b/opcode`).
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer takes result.
- `res_data` out 8: result value.
- `res_rd` out RAW: register written.
- `res_err` out 1: divide-by-zero flag (see Configuration).

## Operation
- FSM states: IDLE, EXEC, WB.
- IDLE: `instr_ready`=1. On `instr_valid && instr_ready`:
  - `instr_ld`=1: `regs[rd] <= imm`; stay IDLE; no result produced.
  - `instr_ld`=0: latch `alu_a <= regs[rs1]`, `alu_b <= regs[rs2]`, `alu_opcode <= op`, latch rd; go to EXEC.
- EXEC: `instr_ready`=0. Sample `alu_out` into result register; `regs[rd] <= alu_out`; go to WB.
- WB: `res_valid`=1, `res_data`/`res_rd`/`res_err` held stable. On `res_ready`, go to IDLE. Otherwise stay.
- Reads in IDLE see all prior writes, including a load or write-back from the immediately preceding edge. No forwarding is needed because operations are serialised.
- Arithmetic is modulo 2^8. Overflow, borrow and multiply high bits are discarded by the ALU; the sequencer adds no width handling.
- `rs1`=`rs2`=`rd` is legal. Operands are read before write-back.

## Timing
- Acceptance at edge T. `alu_*` valid from T to T+1. Result captured and register written at T+1. `res_valid`=1 from T+1.
- Minimum initiation interval is 3 cycles: accept, EXEC, WB with `res_ready`=1.
- `res_ready` low stalls in WB indefinitely. `instr_ready` stays 0 throughout.
- `res_ready` high outside WB is ignored.
- Loads complete in 1 cycle, back-to-back.
- Reset value of every output: `instr_ready`=1, `res_valid`=0, `res_err`=0, `res_data`=0, `res_rd`=0, `alu_a`=0, `alu_b`=0, `alu_opcode`=0. All registers are 0 and the state is IDLE.
- Reset asserted mid-operation discards the pending result. The register write is lost if reset arrives before the EXEC edge.

## Configuration
- `ALU_SEQ_DIV_GUARD_EN` defined:
  - Opcode 0011 with `alu_b`=0 writes 8'hFF to rd.
  - `res_data`=8'hFF and `res_err`=1 for that result.
  - `alu_out` is ignored for that operation.
- `ALU_SEQ_DIV_GUARD_EN` undefined:
  - `res_err` is tied 0.
  - The divide result is whatever `alu_out` returns, written back unmodified.

## Structure
- Package `alu_seq_pkg` holds:
  - `alu_op_e`, the 4-bit opcode enum for all 16 operations.
  - `seq_state_e` (IDLE/EXEC/WB).
  - The div-guard result constant 8'hFF.
- Sub-module `alu_seq_regfile`:
  - NREGS×8 registers.
  - Two combinational read ports and one synchronous write port.
  - Asynchronous active-low clear.
- The top level holds the FSM and handshakes. The ALU itself is external.

## Test plan
- Load r0=8'h0F, r1=8'h01, then ADD r2=r0+r1 → `alu_opcode`=0000, `alu_a`=0F, `alu_b`=01 one cycle after accept. `res_data`=8'h10, `res_rd`=2, r2=10.
- SUB r3=r1−r0 (01−0F) → `res_data`=8'hF2, i.e. wrap-around.
- Hold `res_ready`=0 for 5 cycles in WB → `res_valid`, `res_data` and `res_rd` stable, `instr_ready`=0. Release → IDLE next cycle, `instr_ready`=1.
- Load r1=8'h00, DIV r2=r0/r1:
  - With `ALU_SEQ_DIV_GUARD_EN` → `res_data`=FF, `res_err`=1.
  - Without → `res_err`=0 and the ALU value is passed through.
- Chain SHL r0=r0<<1 three times from r0=8'h81 → results 02, 04, 08, each read-after-write correct.
- Assert `rst_n`=0 during EXEC → all outputs return to reset values, r-file cleared. The next instruction executes normally.
